// File: rtl/rv_debug_pkg.sv
// Shared types and helpers for the debug bridge: command opcodes, FSM states
// and the access-size decode used by both the FSM and the byte sequencer.
package rv_debug_pkg;

  typedef enum logic [2:0] {
    OP_HALT   = 3'd0,
    OP_RESUME = 3'd1,
    OP_STEP   = 3'd2,
    OP_RD_REG = 3'd3,
    OP_WR_REG = 3'd4,
    OP_RD_MEM = 3'd5,
    OP_WR_MEM = 3'd6,
    OP_RD_PC  = 3'd7
  } debug_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT_WAIT,
    ST_STEP_WAIT,
    ST_REG,
    ST_MEM,
    ST_RESP
  } dbg_state_e;

  // Byte counts never exceed 8, so a 4-bit counter covers every access size.
  localparam int unsigned CNT_W = 4;

  function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
    return CNT_W'(1) << size;
  endfunction

endpackage

// File: rtl/rv_debug_bridge_if.sv
// Host command/response channel of the debug bridge.
interface rv_debug_bridge_if
  import rv_debug_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  debug_op_e         cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_size;
  logic [XLEN-1:0]   cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rv_debug_mem_seq.sv
// Byte sequencer: walks a multi-byte access one byte per cycle over the
// byte-wide data-memory port, shifting write data out and read data in.
module rv_debug_mem_seq
  import rv_debug_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  start_bytes,
  input  logic [XLEN-1:0]   start_wdata,
  output logic              done,
  output logic [XLEN-1:0]   rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cap_q, cap_d;
  logic [CNT_W-1:0]  nb_q, nb_d;
  logic [XLEN-1:0]   shift_q, shift_d;
  logic [XLEN-1:0]   assembled;
  logic              issuing;
  logic [6:0]        shamt;

  // Port drive and completion; read bytes enter at the top and the result is
  // right-aligned so byte 0 lands in bits [7:0].
  always_comb begin
    issuing   = busy_q && (idx_q < nb_q);
    assembled = {mem_rdata, shift_q[XLEN-1:8]};
    shamt     = 7'(XLEN) - {nb_q, 3'b000};
    rdata     = assembled >> shamt;
    if (we_q) begin
      done = busy_q && (idx_q == nb_q - 1'b1);
    end else begin
      done = busy_q && pend_q && (cap_q == nb_q - 1'b1);
    end
    mem_addr  = addr_q;
    mem_we    = issuing && we_q;
    mem_wdata = shift_q[7:0];
  end

  // Next-state for address, counters and the data shift register.
  always_comb begin
    busy_d  = busy_q;
    we_d    = we_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    nb_d    = nb_q;
    shift_d = shift_q;
    pend_d  = 1'b0;
    if (start) begin
      busy_d  = 1'b1;
      we_d    = start_we;
      addr_d  = start_addr;
      idx_d   = '0;
      cap_d   = '0;
      nb_d    = start_bytes;
      shift_d = start_we ? start_wdata : '0;
    end else if (busy_q) begin
      if (issuing) begin
        addr_d = addr_q + 1'b1;
        idx_d  = idx_q + 1'b1;
        pend_d = !we_q;
        if (we_q) begin
          shift_d = shift_q >> 8;
        end
      end
      // Read data trails its address by one cycle.
      if (!we_q && pend_q) begin
        shift_d = assembled;
        cap_d   = cap_q + 1'b1;
      end
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  // Sequencer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      cap_q   <= '0;
      nb_q    <= '0;
      shift_q <= '0;
    end else begin
      busy_q  <= busy_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      nb_q    <= nb_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/rv_debug_bridge.sv
// Debug bridge: halts, resumes and single-steps the core and gives the host
// register-file, data-memory and PC access while the core is halted.
module rv_debug_bridge
  import rv_debug_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 16,
  parameter int NREGS   = 32,
  parameter int TIMEOUT = 1024,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  rv_debug_bridge_if.slave  host,
  output logic              core_halt_req,
  input  logic              core_halted,
  output logic              core_step,
  input  logic              core_retired,
  input  logic [XLEN-1:0]   core_pc,
  output logic [RA_W-1:0]   rf_addr,
  output logic              rf_we,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  dbg_state_e        state_q, state_d;
  debug_op_e         op_q, op_d;
  logic              halt_req_q, halt_req_d;
  logic              step_q, step_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [RA_W-1:0]   ra_q, ra_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept, needs_halt, is_mem, mem_bad, cmd_err, tmo_hit;
  logic [CNT_W-1:0]  cmd_bytes;
  logic [ADDR_W:0]   mem_end;
  logic              seq_start, seq_done;
  logic [XLEN-1:0]   seq_rdata;

  // Command decode and admission checks, evaluated on the live command so
  // rejected commands answer in the cycle after acceptance.
  always_comb begin
    accept     = (state_q == ST_IDLE) && host.cmd_valid;
    cmd_bytes  = size_bytes(host.cmd_size);
    mem_end    = {1'b0, host.cmd_addr} + {{(ADDR_W+1-CNT_W){1'b0}}, cmd_bytes};
    mem_bad    = (mem_end > {1'b1, {ADDR_W{1'b0}}}) || ({cmd_bytes, 3'b000} > 7'(XLEN));
    is_mem     = (host.cmd_op == OP_RD_MEM) || (host.cmd_op == OP_WR_MEM);
    needs_halt = !((host.cmd_op == OP_HALT) || (host.cmd_op == OP_RESUME));
    cmd_err    = (needs_halt && !core_halted) || (is_mem && mem_bad);
    tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
  end

  rv_debug_mem_seq #(
    .XLEN  (XLEN),
    .ADDR_W(ADDR_W)
  ) u_mem_seq (
    .clock      (clock),
    .reset      (reset),
    .start      (seq_start),
    .start_we   (host.cmd_op == OP_WR_MEM),
    .start_addr (host.cmd_addr),
    .start_bytes(cmd_bytes),
    .start_wdata(host.cmd_wdata),
    .done       (seq_done),
    .rdata      (seq_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (host.cmd_op == OP_HALT) begin
            state_d = ST_HALT_WAIT;
          end else if (host.cmd_op == OP_RESUME || cmd_err) begin
            state_d = ST_RESP;
          end else if (host.cmd_op == OP_STEP) begin
            state_d = ST_STEP_WAIT;
          end else if (is_mem) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_REG;
          end
        end
      end
      ST_HALT_WAIT: if (core_halted || tmo_hit) state_d = ST_RESP;
      ST_STEP_WAIT: if (core_retired || tmo_hit) state_d = ST_RESP;
      ST_REG:       state_d = ST_RESP;
      ST_MEM:       if (seq_done) state_d = ST_RESP;
      ST_RESP:      if (host.rsp_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    host.cmd_ready = (state_q == ST_IDLE);
    host.rsp_valid = (state_q == ST_RESP);
    host.rsp_data  = rsp_data_q;
    host.rsp_err   = rsp_err_q;
    core_halt_req  = halt_req_q;
    core_step      = step_q;
    rf_addr        = ra_q;
    rf_wdata       = wdata_q;
    rf_we          = (state_q == ST_REG) && (op_q == OP_WR_REG) && (ra_q != '0);
    seq_start      = accept && is_mem && !cmd_err;
  end

  // Datapath: command latch, halt request, step pulse, timeout and response.
  always_comb begin
    op_d       = op_q;
    ra_d       = ra_q;
    wdata_d    = wdata_q;
    halt_req_d = halt_req_q;
    step_d     = 1'b0;
    tmo_d      = tmo_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d       = host.cmd_op;
          ra_d       = host.cmd_addr[RA_W-1:0];
          wdata_d    = host.cmd_wdata;
          tmo_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (host.cmd_op == OP_HALT) begin
            halt_req_d = 1'b1;
          end else if (host.cmd_op == OP_RESUME) begin
            halt_req_d = 1'b0;
          end else if (cmd_err) begin
            rsp_err_d = 1'b1;
          end else if (host.cmd_op == OP_STEP) begin
            step_d = 1'b1;
          end
        end
      end
      ST_HALT_WAIT, ST_STEP_WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        tmo_d = tmo_q + 1'b1;
        if ((state_q == ST_HALT_WAIT) ? core_halted : core_retired) begin
          rsp_err_d = 1'b0;
        end else if (tmo_hit) begin
          rsp_err_d = 1'b1;
        end
      end
      ST_REG: begin
        if (op_q == OP_RD_REG) begin
          rsp_data_d = rf_rdata;
        end else if (op_q == OP_RD_PC) begin
          rsp_data_d = core_pc;
        end
      end
      ST_MEM: begin
        if (seq_done && op_q == OP_RD_MEM) begin
          rsp_data_d = seq_rdata;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q       <= OP_HALT;
      ra_q       <= '0;
      wdata_q    <= '0;
      halt_req_q <= 1'b0;
      step_q     <= 1'b0;
      tmo_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      ra_q       <= ra_d;
      wdata_q    <= wdata_d;
      halt_req_q <= halt_req_d;
      step_q     <= step_d;
      tmo_q      <= tmo_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: doc/rv_debug_bridge.md
# rv_debug_bridge

Parametrised debug bridge between a host command channel and the pipelined RV core. It halts, resumes and single-steps the core. While the core is halted it reads and writes the register file, byte-wide data memory and PC through valid/ready handshakes. It replaces simulation-only hierarchical backdoor access with synthesizable ports usable from a bench or an on-chip host. It sits beside the core, muxed onto the register file and data-memory debug ports.

## Interface
- XLEN, 32: data width; 32 or 64.
- ADDR_W, 16: byte-address width of data memory; memory spans 2^ADDR_W bytes.
- NREGS, 32: register-file entries; RA_W = $clog2(NREGS).
- TIMEOUT, 1024: cycles allowed for halt/step completion before an error response.

Ports (synchronous, active-high reset on `reset`):
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command.
- cmd_op  in  3  HALT=0, RESUME=1, STEP=2, RD_REG=3, WR_REG=4, RD_MEM=5, WR_MEM=6, RD_PC=7.
- cmd_addr  in  ADDR_W  register index (low RA_W bits) or byte address.
- cmd_size  in  2  memory bytes = 1<<cmd_size.
- cmd_wdata  in  XLEN  write data, little-endian for memory.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host takes response.
- rsp_data  out  XLEN  read data, zero-extended; 0 for non-read ops.
- rsp_err  out  1  command failed.
- core_halt_req  out  1  level request to stop fetch and drain the core.
- core_halted  in  1  core is drained and stopped.
- core_step  out  1  one-cycle pulse releasing one instruction.
- core_retired  in  1  pulse on instruction retirement.
- core_pc  in  XLEN  current fetch PC.
- rf_addr  out  RA_W  register index.
- rf_we  out  1  register write strobe.
- rf_wdata  out  XLEN  register write data.
- rf_rdata  in  XLEN  combinational register read data.
- mem_addr  out  ADDR_W  byte address.
- mem_we  out  1  byte write strobe.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid one cycle after the address.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - HALT_WAIT and STEP_WAIT: core handshakes.
  - REG: register access.
  - MEM: memory access.
  - RESP: rsp_valid=1, held until rsp_ready.
- A command is accepted on cmd_valid&&cmd_ready. All command fields are latched at acceptance, so later changes on the cmd_* inputs are ignored.
- HALT:
  - Sets the halt_req register, then enters HALT_WAIT.
  - Goes to RESP when core_halted=1, err=0.
  - Already halted: RESP on the next cycle.
- RESUME: clears halt_req and goes to RESP, err=0.
- STEP:
  - Requires the core to be halted; otherwise RESP with err=1.
  - Pulses core_step for 1 cycle, then STEP_WAIT.
  - Goes to RESP on core_retired, err=0; halt_req stays set.
- RD_REG/WR_REG/RD_MEM/WR_MEM/RD_PC require core_halted=1; otherwise RESP with err=1 and no side effects.
- RD_REG: rsp_data = rf_rdata. WR_REG: one rf_we pulse. A write to index 0 is suppressed and returns err=0.
- RD_PC: rsp_data = core_pc.
- Memory accesses:
  - Error checks, with err=1 and no memory cycle issued:
    - cmd_addr + bytes > 2^ADDR_W.
    - (1<<cmd_size)*8 > XLEN.
  - Unaligned addresses are legal.
  - Byte i goes to address cmd_addr+i and maps to data bits [8i+7:8i].
- Timeout: a counter runs in HALT_WAIT/STEP_WAIT. When it reaches TIMEOUT: RESP with err=1. halt_req keeps its value.
- Any err response carries rsp_data=0.

## Timing
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
  - core_halt_req=0, core_step=0, rf_we=0, mem_we=0, rf_addr=0, mem_addr=0.
  - State is IDLE.
- Reset mid-operation aborts the command. Any in-flight response is dropped, and halt_req is released.
- Cycles counted from the acceptance edge to rsp_valid rising:
  - RD_REG/WR_REG/RD_PC: 2.
  - WR_MEM of N bytes: one byte per cycle in MEM (N cycles), RESP N+1.
  - RD_MEM of N bytes: N+2, owing to 1-cycle memory read latency.
  - Errored command: 1.
  - RESUME: 1.
  - HALT: 1 plus the wait for core_halted.
- rsp_* are stable while rsp_valid=1 and rsp_ready=0.
- RESP→IDLE on rsp_ready, so cmd_ready rises the cycle after the response handshake. There is no command/response overlap.
- core_retired arriving in the same cycle as the timeout is treated as success.

## Structure
- Package rv_debug_pkg holds:
  - the op enum debug_op_e;
  - the state enum;
  - the size→bytes function.
- Sub-module rv_debug_mem_seq: the byte sequencer. It holds the address counter, byte index and assembly shift register, and has start/done handshakes.
- Top level contains the FSM, the timeout counter, halt_req and the response register.

## Test plan
- Reset, then HALT with core_halted raised 5 cycles later → rsp_valid after 6 cycles, err=0, core_halt_req=1.
- Halted; WR_MEM addr=0x0003 size=2 wdata=0xDEADBEEF → bytes EF,BE,AD,DE at 3..6. Then RD_MEM of the same → rsp_data=0xDEADBEEF, latency 6.
- Halted; WR_REG x5=0x12345678 then RD_REG x5 → 0x12345678. WR_REG x0=1 then RD_REG x0 → 0, err=0.
- Not halted; RD_REG x1 → err=1, data=0, latency 1, rf_we never asserted.
- Halted; STEP with core_retired never pulsing → err=1 after TIMEOUT cycles. A retry STEP with core_retired 3 cycles after core_step → err=0.
- RD_MEM addr=0xFFFE size=2 with ADDR_W=16 → err=1, no mem_addr activity. Assert reset during a 4-byte WR_MEM after 2 bytes → IDLE, outputs at reset values, only 2 bytes written.
